alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
Sequential front-end that drives the 4-bit, four-function ALU (add 00, sub 01, AND 10, XOR 11).
- Collects operand A, operand B and function code S one at a time from the board switches, advancing on a pushbutton strobe.
- Presents the operands to the ALU, waits for it to settle, then latches the ALU result and status flags for display.
- Sits between the board I/O (switches, key) and the combinational ALU; it is the initiator side of the ALU's operand/result interface.

Parameters:
WIDTH, 4, operand/result width; must match the ALU.
SETTLE_CYCLES, 1, cycles spent in EXEC before capture; legal range 1-15.
CNT_W, 8, width of the completed-operation counter.

Ports:
Clock  input  1  system clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Din  input  WIDTH  switch value; sampled as A, B, or S (S uses Din[1:0]).
Enter  input  1  level-sensitive pushbutton; only its rising edge advances state.
R  input  WIDTH  ALU result.
Cout  input  1  ALU carry-out.
OVR  input  1  ALU overflow.
A  output  WIDTH  operand A to the ALU.
B  output  WIDTH  operand B to the ALU.
S  output  2  function select to the ALU.
Result  output  WIDTH  latched ALU result.
FlagC  output  1  latched Cout.
FlagV  output  1  latched OVR.
FlagZ  output  1  1 when the latched result is zero.
Busy  output  1  high in EXEC and CAPTURE.
Done  output  1  high in SHOW.
State  output  3  current state encoding, for LEDs/debug.
OpCount  output  CNT_W  completed operations; saturates at all-ones.

Behaviour:
- Reset: synchronous, active-high; all outputs zero; state LOAD_A; edge-detect register cleared. Reset asserted in any state wins over every other event in that cycle.
- Edge detect: Enter is registered; press = Enter & ~Enter_q. A held button yields exactly one press. A press while Busy is ignored.
- States and encoding: LOAD_A=0, LOAD_B=1, LOAD_S=2, EXEC=3, CAPTURE=4, SHOW=5. Codes 6-7 are illegal and go to LOAD_A on the next cycle.
- LOAD_A: on press, A<=Din, go to LOAD_B.
- LOAD_B: on press, B<=Din, go to LOAD_S.
- LOAD_S: on press, S<=Din[1:0], settle counter<=0, go to EXEC.
- EXEC: settle counter increments each cycle; when it reaches SETTLE_CYCLES-1, go to CAPTURE. A, B and S are held stable throughout.
- CAPTURE (exactly 1 cycle):
  - Result<=R, FlagC<=Cout, FlagV<=OVR, FlagZ<=(R==0).
  - OpCount<=OpCount+1 unless already all-ones.
  - Go to SHOW.
- SHOW: Done=1; Result and flags held. On press, go to LOAD_A; A, B and S keep their old values until reloaded.
- Latency: from the LOAD_S press to Done=1 is SETTLE_CYCLES+2 clock edges.
- Result, flags and OpCount change only in CAPTURE or on reset.
- Din may change freely; it is sampled only on the press cycle.

Optional Feature:
ACCUM_CHAIN_EN
- Defined: a press in SHOW does A<=Result and goes to LOAD_B, so a sequence of operations accumulates into A.
- Undefined: a press in SHOW goes to LOAD_A and A is unchanged.
- All other behaviour is identical in both builds.

Decomposition:
- Package alu_seq_pkg holds:
  - state encodings ST_LOAD_A..ST_SHOW;
  - function codes FN_ADD=2'b00, FN_SUB=2'b01, FN_AND=2'b10, FN_XOR=2'b11;
  - default WIDTH.
- One sub-module: rise_pulse, the registered rising-edge detector with synchronous reset.
- FSM, operand registers, settle counter and result latch stay in the top module.

Test Plan:
The bench connects a behavioral ALU model to A, B, S and R, Cout, OVR.
- Add: Din=5 press, Din=3 press, Din=0 press → after SETTLE_CYCLES+2 edges: Result=8, FlagV=1, FlagC=0, FlagZ=0, Done=1, OpCount=1.
- Sub 3−5 (S=01) → Result=14 (1110), FlagV=0, FlagC=0. AND 0xC,0xA (S=10) → Result=8. XOR 0xA,0xA (S=11) → Result=0, FlagZ=1.
- Enter held high for 20 cycles in LOAD_A → only A loaded; state=LOAD_B; no further advance until Enter is released and pressed again.
- Reset asserted for one cycle during EXEC → next cycle state=LOAD_A and all outputs 0; no capture occurs and OpCount stays 0.
- 260 complete operations → OpCount=255 and holds. With ACCUM_CHAIN_EN, 5+3 followed by press, Din=2, S=00 → A=8 and Result=10.
- Presses during EXEC/CAPTURE are ignored → state sequence and latency unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: state codes, ALU function codes
// and the default datapath width.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_S  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_SHOW    = 3'd5
  } state_e;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_XOR = 2'b11;

endpackage

// File: rtl/alu_operand_sequencer_rise_pulse.sv
// rise_pulse: registered rising-edge detector; one-cycle pulse per low-to-high
// transition of din, synchronous active-high reset.
module rise_pulse (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic pulse
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din_d;
    end
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and S from the switches on Enter presses, drives the ALU, waits
// SETTLE_CYCLES, then latches result and flags. Build option: ACCUM_CHAIN_EN.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             Enter,
  input  logic [WIDTH-1:0] R,
  input  logic             Cout,
  input  logic             OVR,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] Result,
  output logic             FlagC,
  output logic             FlagV,
  output logic             FlagZ,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] OpCount
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic press;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [1:0]       s_q,        s_d;
  logic [3:0]       settle_q,   settle_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             flag_c_q,   flag_c_d;
  logic             flag_v_q,   flag_v_d;
  logic             flag_z_q,   flag_z_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  rise_pulse u_enter_edge (
    .clk   (Clock),
    .srst  (Reset),
    .din   (Enter),
    .pulse (press)
  );

  // Presses in EXEC/CAPTURE fall through untouched, which is how Busy ignores them.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    settle_d   = settle_q;
    result_d   = result_q;
    flag_c_d   = flag_c_q;
    flag_v_d   = flag_v_q;
    flag_z_d   = flag_z_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_LOAD_A: begin
        if (press) begin
          a_d     = Din;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (press) begin
          b_d     = Din;
          state_d = ST_LOAD_S;
        end
      end
      ST_LOAD_S: begin
        if (press) begin
          s_d      = Din[1:0];
          settle_d = 4'd0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        result_d = R;
        flag_c_d = Cout;
        flag_v_d = OVR;
        flag_z_d = (R == '0);
        if (op_count_q != '1) begin
          op_count_d = op_count_q + 1'b1;
        end
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (press) begin
`ifdef ACCUM_CHAIN_EN
          a_d     = result_q;
          state_d = ST_LOAD_B;
`else
          state_d = ST_LOAD_A;
`endif
        end
      end
      default: begin
        state_d = ST_LOAD_A;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      settle_q   <= '0;
      result_q   <= '0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      settle_q   <= settle_d;
      result_q   <= result_d;
      flag_c_q   <= flag_c_d;
      flag_v_q   <= flag_v_d;
      flag_z_q   <= flag_z_d;
      op_count_q <= op_count_d;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign S       = s_q;
  assign Result  = result_q;
  assign FlagC   = flag_c_q;
  assign FlagV   = flag_v_q;
  assign FlagZ   = flag_z_q;
  assign OpCount = op_count_q;
  assign State   = state_q;
  assign Busy    = (state_q == ST_EXEC) || (state_q == ST_CAPTURE);
  assign Done    = (state_q == ST_SHOW);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioral 4-bit ALU on its
// operand/result interface; covers both builds of ACCUM_CHAIN_EN.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int SETTLE = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Din;
  logic       Enter;
  logic [3:0] R;
  logic       Cout;
  logic       OVR;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] S;
  logic [3:0] Result;
  logic       FlagC;
  logic       FlagV;
  logic       FlagZ;
  logic       Busy;
  logic       Done;
  logic [2:0] State;
  logic [7:0] OpCount;

  int tests_run    = 0;
  int tests_failed = 0;
  int lat;

  alu_operand_sequencer #(
    .WIDTH(4), .SETTLE_CYCLES(SETTLE), .CNT_W(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Enter(Enter),
    .R(R), .Cout(Cout), .OVR(OVR),
    .A(A), .B(B), .S(S), .Result(Result),
    .FlagC(FlagC), .FlagV(FlagV), .FlagZ(FlagZ),
    .Busy(Busy), .Done(Done), .State(State), .OpCount(OpCount)
  );

  always #5 Clock = ~Clock;

  // Behavioral ALU: subtraction is A + ~B + 1, so Cout means "no borrow".
  logic [4:0] sum;
  always_comb begin
    sum  = 5'd0;
    R    = 4'd0;
    Cout = 1'b0;
    OVR  = 1'b0;
    case (S)
      2'b00: begin
        sum  = {1'b0, A} + {1'b0, B};
        R    = sum[3:0];
        Cout = sum[4];
        OVR  = (A[3] == B[3]) && (sum[3] != A[3]);
      end
      2'b01: begin
        sum  = {1'b0, A} + {1'b0, ~B} + 5'd1;
        R    = sum[3:0];
        Cout = sum[4];
        OVR  = (A[3] != B[3]) && (sum[3] != A[3]);
      end
      2'b10: R = A & B;
      default: R = A ^ B;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // One clean press: Enter low for a cycle, then high across exactly one rising edge.
  task automatic press(input logic [3:0] v);
    Enter = 1'b0;
    @(negedge Clock);
    Din   = v;
    Enter = 1'b1;
    @(negedge Clock);
    Enter = 1'b0;
  endtask

  // Called right after the S press; counts edges until Done, optionally poking Enter while Busy.
  task automatic run_exec(input bit poke, output int n);
    n = 1;
    while (!Done && n < 40) begin
      Enter = (poke && Busy) ? (n % 2 == 0) : 1'b0;
      @(negedge Clock);
      n++;
    end
    Enter = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                       input bit poke, output int n);
    if (State == 3'(ST_SHOW)) press(4'd0);
    if (State == 3'(ST_LOAD_A)) press(a);
    press(b);
    press({2'b00, s});
    run_exec(poke, n);
    $display("[TB] op A=%0d B=%0d S=%0d -> Result=%0d C=%0b V=%0b Z=%0b lat=%0d cnt=%0d",
             A, B, S, Result, FlagC, FlagV, FlagZ, n, OpCount);
  endtask

  initial begin
    Reset = 1'b1;
    Din   = 4'd0;
    Enter = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    check_eq("rst_state", 32'(State), 0);
    check_eq("rst_abs", 32'({A, B, S}), 0);
    check_eq("rst_result", 32'({Result, FlagC, FlagV, FlagZ}), 0);
    check_eq("rst_busy_done", 32'({Busy, Done}), 0);
    check_eq("rst_opcount", 32'(OpCount), 0);

    // 5 + 3 = 8 overflows in signed 4-bit.
    do_op(4'd5, 4'd3, FN_ADD, 1'b0, lat);
    check_eq("add_latency", 32'(lat), SETTLE + 2);
    check_eq("add_done", 32'(Done), 1);
    check_eq("add_result", 32'(Result), 8);
    check_eq("add_cvz", 32'({FlagC, FlagV, FlagZ}), 32'b010);
    check_eq("add_opcount", 32'(OpCount), 1);
    check_eq("add_state", 32'(State), 5);
    press(4'd9);
`ifdef ACCUM_CHAIN_EN
    check_eq("show_exit_state", 32'(State), 1);
    check_eq("show_exit_a", 32'(A), 8);
`else
    check_eq("show_exit_state", 32'(State), 0);
    check_eq("show_exit_a", 32'(A), 5);
`endif

    pulse_reset();
    do_op(4'd3, 4'd5, FN_SUB, 1'b0, lat);
    check_eq("sub_result", 32'(Result), 14);
    check_eq("sub_cvz", 32'({FlagC, FlagV, FlagZ}), 32'b000);

    pulse_reset();
    do_op(4'hC, 4'hA, FN_AND, 1'b0, lat);
    check_eq("and_result", 32'(Result), 8);

    pulse_reset();
    do_op(4'hA, 4'hA, FN_XOR, 1'b0, lat);
    check_eq("xor_result", 32'(Result), 0);
    check_eq("xor_z", 32'(FlagZ), 1);

    pulse_reset();
    do_op(4'hF, 4'h1, FN_ADD, 1'b0, lat);
    check_eq("wrap_result", 32'(Result), 0);
    check_eq("wrap_cvz", 32'({FlagC, FlagV, FlagZ}), 32'b101);

    // Enter held high for 20 cycles loads only A.
    pulse_reset();
    Din   = 4'd7;
    Enter = 1'b1;
    @(negedge Clock);
    Din = 4'd9;
    repeat (19) @(negedge Clock);
    check_eq("hold_state", 32'(State), 1);
    check_eq("hold_a", 32'(A), 7);
    check_eq("hold_b", 32'(B), 0);
    Enter = 1'b0;
    @(negedge Clock);
    check_eq("hold_release_state", 32'(State), 1);
    press(4'd2);
    check_eq("hold_next_b", 32'(B), 2);
    check_eq("hold_next_state", 32'(State), 2);

    // Presses during EXEC/CAPTURE must not disturb sequence or latency.
    press({2'b00, FN_SUB});
    run_exec(1'b1, lat);
    $display("[TB] busy-poke op 7-2 -> Result=%0d lat=%0d", Result, lat);
    check_eq("poke_latency", 32'(lat), SETTLE + 2);
    check_eq("poke_result", 32'(Result), 5);
    check_eq("poke_state", 32'(State), 5);

    // Reset in EXEC aborts the operation before capture.
    pulse_reset();
    press(4'd1);
    press(4'd2);
    press({2'b00, FN_ADD});
    check_eq("exec_busy", 32'(Busy), 1);
    pulse_reset();
    check_eq("exec_rst_state", 32'(State), 0);
    check_eq("exec_rst_abs", 32'({A, B, S}), 0);
    check_eq("exec_rst_result", 32'({Result, FlagC, FlagV, FlagZ, Busy, Done}), 0);
    repeat (5) @(negedge Clock);
    check_eq("exec_rst_opcount", 32'(OpCount), 0);
    check_eq("exec_rst_idle", 32'(State), 0);

    // Saturating operation counter.
    for (int i = 0; i < 260; i++) begin
      do_op(4'd1, 4'd1, FN_ADD, 1'b0, lat);
      if (i == 253) check_eq("cnt_254", 32'(OpCount), 254);
      if (i == 254) check_eq("cnt_255", 32'(OpCount), 255);
    end
    check_eq("cnt_sat", 32'(OpCount), 255);
`ifndef ACCUM_CHAIN_EN
    check_eq("cnt_last_result", 32'(Result), 2);
`endif

`ifdef ACCUM_CHAIN_EN
    pulse_reset();
    do_op(4'd5, 4'd3, FN_ADD, 1'b0, lat);
    press(4'd0);
    check_eq("accum_a", 32'(A), 8);
    check_eq("accum_state", 32'(State), 1);
    press(4'd2);
    press({2'b00, FN_ADD});
    run_exec(1'b0, lat);
    check_eq("accum_result", 32'(Result), 10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
